// File: rtl/iter_alu.sv
// Iterative 32-bit ALU: single-cycle logic/arith ops, one-bit-per-cycle shifts,
// valid/ready handshake on both sides with synchronous flush.
module iter_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic        busy
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001
    } op_e;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e      state, state_next;
    logic [31:0] work;
    logic [31:0] result;
    logic [31:0] alu_val;
    logic [31:0] shift_one;
    logic [4:0]  cnt;
    logic [1:0]  shift_op;
    logic        is_shift;
    logic        accept;

    assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) || (ALUControl == OP_SRA);
    assign accept   = (state == IDLE) && in_valid;

    // NOTE: every always_comb output gets a default first, otherwise an unlisted
    // case branch keeps the old value and synthesis infers a latch.
    always_comb begin
        alu_val = '0;
        case (ALUControl)
            OP_ADD:  alu_val = SrcA + SrcB;
            OP_SUB:  alu_val = SrcA - SrcB;
            OP_AND:  alu_val = SrcA & SrcB;
            OP_OR:   alu_val = SrcA | SrcB;
            OP_XOR:  alu_val = SrcA ^ SrcB;
            OP_SLL, OP_SRL, OP_SRA: alu_val = SrcA;  // only used when shamt == 0
            OP_SLT:  alu_val = {31'b0, $signed(SrcA) < $signed(SrcB)};
            OP_SLTU: alu_val = {31'b0, SrcA < SrcB};
            default: alu_val = '0;
        endcase
    end

    // shift_op holds the low opcode bits: 01 sll, 10 srl, 11 sra
    always_comb begin
        shift_one = work;
        case (shift_op)
            2'b01:   shift_one = {work[30:0], 1'b0};
            2'b10:   shift_one = {1'b0, work[31:1]};
            2'b11:   shift_one = {work[31], work[31:1]};
            default: shift_one = work;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (in_valid) state_next = (is_shift && SrcB[4:0] != 5'd0) ? SHIFT : DONE;
            SHIFT: if (cnt == 5'd1) state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        ALUResult = result;
        Zero      = (result == 32'h0);
    end

    // result is written only when the final value is known, so Zero never
    // reflects a partially shifted operand.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work     <= '0;
            result   <= '0;
            cnt      <= '0;
            shift_op <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    work     <= SrcA;
                    cnt      <= SrcB[4:0];
                    shift_op <= ALUControl[1:0];
                    if (!(is_shift && SrcB[4:0] != 5'd0)) result <= alu_val;
                end
                SHIFT: begin
                    work <= shift_one;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) result <= shift_one;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port flush, input, 1 bit: synchronous abort of any in-flight operation.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand/opcode bundle is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a bundle.
REQ-006 The block SHALL have port ALUControl, input, 4 bits: operation code from the ALU decoder.
REQ-007 The block SHALL have ports SrcA and SrcB, input, 32 bits each: operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port ALUResult, output, 32 bits: the result.
REQ-011 The block SHALL have port Zero, output, 1 bit: ALUResult == 0, valid while out_valid.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 Opcodes SHALL be decoded as follows:
- 0000 add
- 0001 sub
- 0010 and
- 0011 or
- 0100 xor
- 0101 sll
- 0110 srl
- 0111 sra
- 1000 slt (signed, result 0/1)
- 1001 sltu (unsigned, result 0/1)
- 1010..1111: result 32'h0
REQ-014 Arithmetic SHALL be 32-bit modulo 2^32; carries and overflow are discarded.
REQ-015 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a bundle is accepted when in_valid && in_ready at a rising edge.
REQ-017 On accept, the opcode, SrcA and SrcB SHALL be latched; later input changes SHALL NOT affect the result.
REQ-018 For a non-shift opcode accepted at edge N, the FSM SHALL move IDLE->DONE with the result registered, so out_valid=1 after edge N (latency 1).
REQ-019 For sll/srl/sra, shamt SHALL be the latched SrcB[4:0] and SrcB[31:5] SHALL be ignored.
REQ-020 If shamt == 0, the FSM SHALL go IDLE->DONE with result SrcA (latency 1).
REQ-021 If shamt == k > 0, the FSM SHALL enter SHIFT and shift the working register one bit per cycle, with a 5-bit down-counter loaded with k.
- sra shifts in the sign bit; sll/srl shift in zeros.
- After k shift edges, the FSM SHALL enter DONE, so out_valid rises after edge N+k (latency k, maximum 31).
REQ-022 In DONE, out_valid=1 and ALUResult/Zero SHALL hold stable until out_valid && out_ready; the FSM then returns to IDLE.
REQ-023 out_ready SHALL be ignored outside DONE; out_valid SHALL be 0 in IDLE and SHIFT.
REQ-024 Throughput: the earliest next accept SHALL be the edge after the result handshake; one non-shift op per 2 cycles when out_ready is held at 1.
REQ-025 Zero SHALL be computed from the final result, not from intermediate shift values.
REQ-026 flush=1 at an edge SHALL force IDLE, clear out_valid and discard any in-flight result; an in_valid that coincides with flush SHALL NOT be accepted.
REQ-027 If rst_n and flush are both asserted, reset SHALL take priority; the outcome is identical.

Reset
REQ-028 While rst_n=0 at an edge, the FSM SHALL enter IDLE, with out_valid=0, ALUResult=32'h0, Zero=1, busy=0 and the shift counter=0.
REQ-029 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 from the first edge after rst_n returns to 1.
REQ-030 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no out_valid pulse SHALL follow.

Verification
REQ-031 The bench SHALL drive add: op 0000, A=32'hFFFF_FFFF, B=1 -> out_valid after 1 edge, ALUResult=0, Zero=1.
REQ-032 The bench SHALL drive slt and sltu: op 1000, A=32'h8000_0000, B=1 -> 1; op 1001 with the same operands -> 0.
REQ-033 The bench SHALL drive sra: op 0111, A=32'h8000_0000, B=32'h0000_0023 (shamt 3) -> busy for 3 edges, then ALUResult=32'hF000_0000, Zero=0.
REQ-034 The bench SHALL check backpressure: op 0001, A=5, B=5, out_ready held 0 for 4 cycles -> out_valid, ALUResult=0 and Zero=1 stable; in_ready=0 until the edge after out_ready=1.
REQ-035 The bench SHALL check flush: sll shamt 31 accepted, flush asserted at shift edge 10 -> IDLE the next cycle, no out_valid; a new add A=2, B=3 then returns 5.
REQ-036 The bench SHALL check reset: rst_n=0 during SHIFT of srl shamt 8 -> all outputs at reset values, and no result follows after rst_n=1.
